// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake, IF/ID register.
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_flush_cnt counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        pc_ld,
   input  logic        IF_ID_write,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [1:0]  dbg_state
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   // imem handshake: imem_req stays high with imem_addr stable until the cycle
   // imem_ack is seen; exactly one request is ever outstanding.
   typedef enum logic [1:0] {S_REQ = 2'd0, S_HOLD = 2'd1, S_DROP = 2'd2} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] req_addr, req_addr_n;
   logic [31:0] hold_buf, hold_n;
   logic [31:0] inst_n, pc4_n;
   logic        valid_n;
   logic        advance;
   logic [31:0] redirect_al;
   logic [31:0] pc_plus4;

   assign advance     = pc_ld & IF_ID_write;
   assign redirect_al = redirect_pc & ~32'h3;
   assign pc_plus4    = pc + 32'd4;
   assign imem_req    = !rst && (state != S_HOLD);
   assign imem_addr   = req_addr;
   assign dbg_state   = state;

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      req_addr_n = req_addr;
      hold_n     = hold_buf;
      inst_n     = if_id_inst;
      pc4_n      = if_id_pc4;
      valid_n    = if_id_valid;
      if (flush) begin
         pc_n    = redirect_al;
         hold_n  = '0;
         inst_n  = NOP_INST;
         valid_n = 1'b0;
         // Only a completed (or absent) request may be replaced; otherwise drain it in DROP.
         if ((state == S_HOLD) || imem_ack) begin
            state_n    = S_REQ;
            req_addr_n = redirect_al;
         end else begin
            state_n = S_DROP;
         end
      end else begin
         case (state)
            S_REQ: begin
               if (imem_ack && advance) begin
                  inst_n     = imem_rdata;
                  pc4_n      = req_addr + 32'd4;
                  valid_n    = 1'b1;
                  pc_n       = pc_plus4;
                  req_addr_n = pc_plus4;
               end else if (imem_ack) begin
                  hold_n  = imem_rdata;
                  state_n = S_HOLD;
               end else if (IF_ID_write) begin
                  inst_n  = NOP_INST;
                  valid_n = 1'b0;
               end
            end
            S_HOLD: begin
               if (advance) begin
                  inst_n     = hold_buf;
                  pc4_n      = pc_plus4;
                  valid_n    = 1'b1;
                  pc_n       = pc_plus4;
                  req_addr_n = pc_plus4;
                  state_n    = S_REQ;
               end
            end
            S_DROP: begin
               inst_n  = NOP_INST;
               valid_n = 1'b0;
               if (imem_ack) begin
                  state_n    = S_REQ;
                  req_addr_n = pc;
               end
            end
            default: state_n = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         hold_buf    <= '0;
         if_id_inst  <= NOP_INST;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         req_addr    <= req_addr_n;
         hold_buf    <= hold_n;
         if_id_inst  <= inst_n;
         if_id_pc4   <= pc4_n;
         if_id_valid <= valid_n;
      end
   end

`ifdef FETCH_PERF_EN
   logic fetch_load;
   assign fetch_load = !flush && valid_n &&
                       (((state == S_REQ) && imem_ack && advance) || ((state == S_HOLD) && advance));

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (fetch_load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (flush)      perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem model with programmable latency,
// expected-delivery queue checked by a negedge monitor.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        pc_ld;
   logic        if_id_write;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [3:0]  lat;
   logic [3:0]  wait_cnt;
   logic        adv_q;

   fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .pc_ld       (pc_ld),
      .IF_ID_write (if_id_write),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .if_id_inst  (if_id_inst),
      .if_id_pc4   (if_id_pc4),
      .if_id_valid (if_id_valid),
      .dbg_state   (dbg_state)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // imem model: ack after 'lat' wait cycles, content derived from the address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   assign imem_ack   = imem_req && (wait_cnt >= lat);
   assign imem_rdata = mem_word(imem_addr);

   always @(posedge clk) begin
      if (rst || !imem_req || imem_ack) wait_cnt <= '0;
      else                              wait_cnt <= wait_cnt + 4'd1;
      adv_q <= pc_ld && if_id_write && !rst;
   end

   // scoreboard monitor: every valid IF/ID after an advancing edge is a new delivery
   always @(negedge clk) begin
      if (adv_q && if_id_valid) begin
         logic [63:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_delivery got inst=%h pc4=%h, queue empty", if_id_inst, if_id_pc4);
         end else begin
            e = exp_q.pop_front();
            if ({if_id_inst, if_id_pc4} !== e) begin
               errors++;
               $display("FAIL delivery got inst=%h pc4=%h expected inst=%h pc4=%h",
                        if_id_inst, if_id_pc4, e[63:32], e[31:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_fetch(input logic [31:0] addr);
      exp_q.push_back({mem_word(addr), addr + 32'd4});
   endtask

   task automatic wait_ack(input int maxc);
      int n;
      n = 0;
      while (!imem_ack && n < maxc) begin
         tick();
         n++;
      end
      if (!imem_ack) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout got no ack after %0d cycles", maxc);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; pc_ld = 1'b1; if_id_write = 1'b1;
      redirect_pc = '0; lat = 4'd0;
      repeat (2) tick();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_inst", if_id_inst, 32'h0);
      chk("rst_pc4", if_id_pc4, 32'h0);
      chk("rst_valid", {31'd0, if_id_valid}, 32'd0);

      // zero-wait streaming: one instruction per cycle
      expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8); expect_fetch(32'hC);
      rst = 1'b0;
      #1;
      chk("t1_addr0", imem_addr, 32'h0);
      chk("t1_req", {31'd0, imem_req}, 32'd1);
      tick(); chk("t1_addr1", imem_addr, 32'h4);
      tick(); chk("t1_addr2", imem_addr, 32'h8);
      tick(); chk("t1_addr3", imem_addr, 32'hC);
      tick(); chk("t1_addr4", imem_addr, 32'h10);

      // stall for two cycles while the ack for 0x10 lands -> HOLD
      pc_ld = 1'b0; if_id_write = 1'b0;
      tick();
      chk("t3_hold_req", {31'd0, imem_req}, 32'd0);
      chk("t3_hold_state", {30'd0, dbg_state}, 32'd1);
      tick();
      chk("t3_hold_req2", {31'd0, imem_req}, 32'd0);
      chk("t3_kept_pc4", if_id_pc4, 32'h10);
      expect_fetch(32'h10);
      pc_ld = 1'b1; if_id_write = 1'b1; lat = 4'd3;
      tick();
      chk("t3_next_addr", imem_addr, 32'h14);

      // latency 3: bubbles between deliveries
      expect_fetch(32'h14);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t2_bubble_valid", {31'd0, if_id_valid}, 32'd0);
         chk("t2_bubble_inst", if_id_inst, 32'h0);
      end
      chk("t2_ack_latency", {31'd0, imem_ack}, 32'd1);
      tick();
      expect_fetch(32'h18);
      wait_ack(10);
      tick();
      chk("t2_addr", imem_addr, 32'h1C);

      // flush while request pending -> DROP, stale data discarded
      flush = 1'b1; redirect_pc = 32'h40;
      tick();
      flush = 1'b0;
      chk("t4_drop_state", {30'd0, dbg_state}, 32'd2);
      chk("t4_addr_stable", imem_addr, 32'h1C);
      chk("t4_drop_req", {31'd0, imem_req}, 32'd1);
      wait_ack(10);
      tick();
      chk("t4_redirect_addr", imem_addr, 32'h40);
      chk("t4_no_stale", {31'd0, if_id_valid}, 32'd0);
      expect_fetch(32'h40);
      wait_ack(10);
      tick();

      // flush on an ack cycle, misaligned redirect
      wait_ack(10);
      flush = 1'b1; redirect_pc = 32'h103;
      tick();
      flush = 1'b0;
      chk("t5_bubble", {31'd0, if_id_valid}, 32'd0);
      chk("t5_addr", imem_addr, 32'h100);
      expect_fetch(32'h100);
      wait_ack(10);
      tick();

      // PC wrap at the top of the address space
      flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      flush = 1'b0;
      wait_ack(10);
      tick();
      chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
      expect_fetch(32'hFFFF_FFFC);
      wait_ack(10);
      tick();
      chk("t6_wrap_addr", imem_addr, 32'h0);
      chk("t6_wrap_pc4", if_id_pc4, 32'h0);

      // reset in the middle of DROP
      flush = 1'b1; redirect_pc = 32'h200;
      tick();
      flush = 1'b0;
      chk("t7_drop_state", {30'd0, dbg_state}, 32'd2);
      rst = 1'b1;
      #1;
      chk("t7_rst_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("t7_rst_inst", if_id_inst, 32'h0);
      chk("t7_rst_pc4", if_id_pc4, 32'h0);
      chk("t7_rst_valid", {31'd0, if_id_valid}, 32'd0);
      chk("t7_rst_state", {30'd0, dbg_state}, 32'd0);
      rst = 1'b0;
      #1;
      chk("t7_addr", imem_addr, 32'h0);
      chk("t7_req", {31'd0, imem_req}, 32'd1);
      expect_fetch(32'h0);
      wait_ack(10);
      tick();
      pc_ld = 1'b0; if_id_write = 1'b0;
`ifdef FETCH_PERF_EN
      chk("perf_fetch", perf_fetch_cnt, 32'd1);
      chk("perf_flush", perf_flush_cnt, 32'd0);
`endif
      repeat (6) tick();
      chk("drain", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
